// File: rtl/pcm_to_i2s_pkg.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s_pkg
// Shared parameter defaults, FSM state type and width helpers for the
// PCM-to-I2S transmitter (pcm_to_i2s) and its frame timer (i2s_frame_timer).
// ---------------------------------------------------------------------------
package pcm_to_i2s_pkg;

    localparam int DEF_NUMBER_OF_BITS = 16;  // sample width per channel
    localparam int DEF_SLOT_BITS      = 32;  // clk cycles per channel slot

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } i2s_state_e;

    // Bit counter spans one full frame: 0 .. 2*slot_bits-1.
    function automatic int cnt_width(input int slot_bits);
        return $clog2(2 * slot_bits);
    endfunction

    // Index width into one sample word; never narrower than 1 bit.
    function automatic int idx_width(input int nbits);
        return (nbits > 1) ? $clog2(nbits) : 1;
    endfunction

endpackage

// File: rtl/pcm_to_i2s_frame_timer.sv
// ---------------------------------------------------------------------------
// i2s_frame_timer
// IDLE/ACTIVE frame sequencer. Owns the frame bit counter, word select and
// busy. A new frame starts whenever en is seen at IDLE or on the last bit of
// a frame; a frame in progress always runs to its last bit.
//
// Ports
//   clk, rst_n     clock, async active-low reset
//   en             transmit enable, only acted on at frame boundaries
//   bit_cnt        position within the frame (0 .. 2*SLOT_BITS-1)
//   frame_start    combinational strobe: this edge starts a frame
//   last_bit       combinational: ACTIVE and on the final bit of the frame
//   ws             registered word select (0 = left, 1 = right)
//   busy           high while ACTIVE
// ---------------------------------------------------------------------------
module i2s_frame_timer
    import pcm_to_i2s_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int CW        = cnt_width(SLOT_BITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] bit_cnt,
    output logic          frame_start,
    output logic          last_bit,
    output logic          ws,
    output logic          busy
);

    i2s_state_e    r_state, w_state_nxt;
    logic [CW-1:0] r_bit_cnt, w_cnt_nxt, w_cnt_inc;
    logic          r_ws, w_ws_nxt;
    logic          w_last, w_frame_start;

    assign w_last        = (r_state == ST_ACTIVE) && (r_bit_cnt == CW'(2 * SLOT_BITS - 1));
    assign w_frame_start = en && ((r_state == ST_IDLE) || w_last);
    assign w_cnt_inc     = r_bit_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
            r_ws      <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_cnt_nxt;
            r_ws      <= w_ws_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_ws_nxt    = r_ws;
        if (w_frame_start) begin
            w_state_nxt = ST_ACTIVE;
            w_cnt_nxt   = '0;
            w_ws_nxt    = 1'b0;
        end else if (w_last) begin
            // en low on the final bit: frame done, park in IDLE
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_ws_nxt    = 1'b0;
        end else if (r_state == ST_ACTIVE) begin
            // ws follows the incremented count so it flips on entry to slot R
            w_cnt_nxt = w_cnt_inc;
            w_ws_nxt  = (w_cnt_inc >= CW'(SLOT_BITS));
        end
    end

    assign bit_cnt     = r_bit_cnt;
    assign frame_start = w_frame_start;
    assign last_bit    = w_last;
    assign ws          = r_ws;
    assign busy        = (r_state == ST_ACTIVE);

endmodule

// File: rtl/pcm_to_i2s.sv
// ---------------------------------------------------------------------------
// pcm_to_i2s
// Serialises left/right PCM sample pairs into a standard I2S stream. A
// one-deep holding register decouples the producer from frame timing; each
// frame start moves the held pair into the frame registers (or zeros plus an
// underrun pulse when nothing is held). Data is MSB first, one clk after ws
// changes, zero padded to SLOT_BITS per channel.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   en                     transmit enable (sampled at frame boundaries)
//   pcm_valid/pcm_ready    sample-pair handshake; ready = holding reg empty
//   pcm_left/pcm_right     two's-complement samples
//   ws, sd                 registered I2S word select / serial data
//   underrun               1-cycle pulse: frame started with nothing held
//   busy                   frame in progress
// ---------------------------------------------------------------------------
module pcm_to_i2s
    import pcm_to_i2s_pkg::*;
#(
    parameter int NUMBER_OF_BITS = DEF_NUMBER_OF_BITS,
    parameter int SLOT_BITS      = DEF_SLOT_BITS
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      pcm_valid,
    output logic                      pcm_ready,
    input  logic [NUMBER_OF_BITS-1:0] pcm_left,
    input  logic [NUMBER_OF_BITS-1:0] pcm_right,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun,
    output logic                      busy
);

    localparam int CW = cnt_width(SLOT_BITS);
    localparam int IW = idx_width(NUMBER_OF_BITS);

    logic [NUMBER_OF_BITS-1:0] r_hold_l, r_hold_r;
    logic [NUMBER_OF_BITS-1:0] r_frame_l, r_frame_r;
    logic                      r_hold_full;
    logic                      r_sd, r_underrun;

    logic [CW-1:0]             w_bit_cnt;
    logic                      w_frame_start, w_last, w_busy, w_capture, w_sd_nxt;
    logic [IW-1:0]             w_idx_l, w_idx_r;
    int                        w_k;

    i2s_frame_timer #(
        .SLOT_BITS (SLOT_BITS),
        .CW        (CW)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .bit_cnt     (w_bit_cnt),
        .frame_start (w_frame_start),
        .last_bit    (w_last),
        .ws          (ws),
        .busy        (w_busy)
    );

    assign pcm_ready = !r_hold_full;
    assign w_capture = pcm_valid && !r_hold_full;

    // Serial bit for the next position k = bit_cnt+1; out-of-range index
    // values are computed but never selected.
    always_comb begin
        w_k      = int'(w_bit_cnt) + 1;
        w_idx_l  = IW'(NUMBER_OF_BITS - w_k);
        w_idx_r  = IW'(NUMBER_OF_BITS + SLOT_BITS - w_k);
        w_sd_nxt = 1'b0;
        if (w_busy && !w_last) begin
            if (w_k <= NUMBER_OF_BITS)
                w_sd_nxt = r_frame_l[w_idx_l];
            else if (w_k >= SLOT_BITS + 1 && w_k <= SLOT_BITS + NUMBER_OF_BITS)
                w_sd_nxt = r_frame_r[w_idx_r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_l    <= '0;
            r_hold_r    <= '0;
            r_hold_full <= 1'b0;
            r_frame_l   <= '0;
            r_frame_r   <= '0;
            r_sd        <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sd       <= w_sd_nxt;
            r_underrun <= 1'b0;
            if (w_frame_start) begin
                r_frame_l  <= r_hold_full ? r_hold_l : '0;
                r_frame_r  <= r_hold_full ? r_hold_r : '0;
                r_underrun <= !r_hold_full;
            end
            // A capture can only happen with the holder empty, so on a
            // frame-start edge the current frame is already zeros and the
            // new pair waits for the next frame.
            if (w_capture) begin
                r_hold_l    <= pcm_left;
                r_hold_r    <= pcm_right;
                r_hold_full <= 1'b1;
            end else if (w_frame_start) begin
                r_hold_full <= 1'b0;
            end
        end
    end

    assign sd       = r_sd;
    assign underrun = r_underrun;
    assign busy     = w_busy;

endmodule

// File: tb/tb_pcm_to_i2s.sv
module tb_pcm_to_i2s;

    localparam int N = 16;
    localparam int S = 32;
    localparam int F = 2 * S;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         en = 1'b0;
    logic         pcm_valid = 1'b0;
    logic [N-1:0] pcm_left = '0;
    logic [N-1:0] pcm_right = '0;
    logic         pcm_ready, ws, sd, underrun, busy;

    int n_cmp = 0;
    int n_bad = 0;

    pcm_to_i2s #(.NUMBER_OF_BITS(N), .SLOT_BITS(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pcm_left  (pcm_left),
        .pcm_right (pcm_right),
        .ws        (ws),
        .sd        (sd),
        .underrun  (underrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A frame is a 2*S-bit picture of sd, MSB = position 0: one delay bit,
    // left sample, padding, one delay bit, right sample, padding.
    logic         m_hold_full = 1'b0;
    logic [N-1:0] m_hold_l = '0, m_hold_r = '0;
    logic         m_active = 1'b0;
    int           m_pos = 0;
    logic [F-1:0] m_frame = '0;
    logic         m_underrun = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_hold_full = 1'b0;
            m_hold_l    = '0;
            m_hold_r    = '0;
            m_active    = 1'b0;
            m_pos       = 0;
            m_frame     = '0;
            m_underrun  = 1'b0;
        end else begin
            logic start, cap, frame_end;
            logic [N-1:0] fl, fr;
            frame_end  = m_active && (m_pos == F - 1);
            start      = en && (!m_active || frame_end);
            cap        = pcm_valid && !m_hold_full;
            m_underrun = 1'b0;
            if (start) begin
                fl         = m_hold_full ? m_hold_l : '0;
                fr         = m_hold_full ? m_hold_r : '0;
                m_frame    = (F'(fl) << (F - 1 - N)) | (F'(fr) << (S - 1 - N));
                m_underrun = !m_hold_full;
                m_hold_full = 1'b0;
                m_active   = 1'b1;
                m_pos      = 0;
            end else if (frame_end) begin
                m_active = 1'b0;
                m_pos    = 0;
            end else if (m_active) begin
                m_pos = m_pos + 1;
            end
            if (cap) begin
                m_hold_l    = pcm_left;
                m_hold_r    = pcm_right;
                m_hold_full = 1'b1;
            end
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [F-1:0] sh;
        logic e_ws, e_sd;
        sh   = m_frame << m_pos;
        e_ws = m_active && (m_pos >= S);
        e_sd = m_active && sh[F-1];
        chk("ws",        64'(ws),        64'(e_ws));
        chk("sd",        64'(sd),        64'(e_sd));
        chk("busy",      64'(busy),      64'(m_active));
        chk("underrun",  64'(underrun),  64'(m_underrun));
        chk("pcm_ready", 64'(pcm_ready), 64'(!m_hold_full));
    end

    // Record one whole frame starting at the first falling edge after the
    // frame-start edge. en is dropped at position drop_at (if >= 0).
    task automatic run_frame(input int drop_at, input bit clr_valid,
                             output logic [63:0] sdv, output logic [63:0] wsv,
                             output int urn);
        sdv = '0; wsv = '0; urn = 0;
        for (int p = 0; p < F; p++) begin
            @(negedge clk);
            sdv[F-1-p] = sd;
            wsv[F-1-p] = ws;
            urn += int'(underrun);
            if (p == 0 && clr_valid) pcm_valid = 1'b0;
            if (p == drop_at) en = 1'b0;
        end
    endtask

    logic [63:0] sdv, wsv, exp_v, ws_exp;
    int          urn;

    initial begin
        ws_exp = {32'h0000_0000, 32'hFFFF_FFFF};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ws",    64'(ws),        64'd0);
        chk("rst_sd",    64'(sd),        64'd0);
        chk("rst_busy",  64'(busy),      64'd0);
        chk("rst_ready", 64'(pcm_ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // A: capture coincides with the first frame start -> zeros + underrun,
        // sample goes out in the second frame; en dropped at bit 10 of it.
        en = 1'b1; pcm_valid = 1'b1; pcm_left = 16'h1234; pcm_right = 16'h1234;
        run_frame(-1, 1'b1, sdv, wsv, urn);
        chk("A1_sd",  sdv, 64'd0);
        chk("A1_ws",  wsv, ws_exp);
        chk("A1_urn", 64'(urn), 64'd1);
        run_frame(10, 1'b0, sdv, wsv, urn);
        exp_v = {1'b0, 16'h1234, 16'h0000, 16'h1234, 15'h0000};
        chk("A2_sd",  sdv, exp_v);
        chk("A2_ws",  wsv, ws_exp);
        chk("A2_urn", 64'(urn), 64'd0);
        @(negedge clk);
        chk("A_idle_busy", 64'(busy), 64'd0);
        chk("A_idle_ws",   64'(ws),   64'd0);
        chk("A_idle_sd",   64'(sd),   64'd0);

        // B: pair accepted while IDLE, retained, then sent.
        pcm_valid = 1'b1; pcm_left = 16'hA5C3; pcm_right = 16'h0F01;
        @(negedge clk);
        pcm_valid = 1'b0;
        chk("B_ready_held", 64'(pcm_ready), 64'd0);
        repeat (3) @(negedge clk);
        en = 1'b1;
        run_frame(0, 1'b0, sdv, wsv, urn);
        exp_v = {1'b0, 16'hA5C3, 16'h0000, 16'h0F01, 15'h0000};
        chk("B_sd",       sdv, exp_v);
        chk("B_model",    m_frame, exp_v);
        chk("B_urn",      64'(urn), 64'd0);
        repeat (2) @(negedge clk);

        // C: pairs offered back to back across four frames.
        en = 1'b1; pcm_valid = 1'b1; pcm_left = 16'h1000; pcm_right = 16'hEFFF;
        urn = 0;
        for (int c = 0; c < 4 * F; c++) begin
            @(negedge clk);
            urn += int'(underrun);
            if (!pcm_ready) begin
                pcm_left  = pcm_left + 16'h0011;
                pcm_right = ~pcm_left;
            end
            if (c == 3 * F + 8) en = 1'b0;
        end
        pcm_valid = 1'b0;
        chk("C_urn", 64'(urn), 64'd1);
        repeat (2) @(negedge clk);

        // D: async reset at bit 40 of a frame.
        en = 1'b1;
        for (int p = 0; p <= 40; p++) @(negedge clk);
        chk("D_pre_busy", 64'(busy), 64'd1);
        chk("D_pre_ws",   64'(ws),   64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("D_rst_ws",    64'(ws),        64'd0);
        chk("D_rst_sd",    64'(sd),        64'd0);
        chk("D_rst_busy",  64'(busy),      64'd0);
        chk("D_rst_ready", 64'(pcm_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 1'b0, sdv, wsv, urn);
        chk("D_post_sd",  sdv, 64'd0);
        chk("D_post_ws",  wsv, ws_exp);
        chk("D_post_urn", 64'(urn), 64'd1);
        @(negedge clk);
        chk("D_end_busy", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
